// File: rtl/io_input_reg.sv
// Three synchronized 32-bit input ports with per-port change flags and a CPU read decode.
// Define IO_DEBOUNCE_EN to add a per-port debounce filter of DEBOUNCE_CYCLES stable edges.
module io_input_reg #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        io_clk,
  input  logic        clrn,
  input  logic [31:0] addr,
  input  logic        read_io_enable,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  input  logic [31:0] in_port2,
  output logic [31:0] dataout,
  output logic        io_irq
);

  localparam logic [5:0] ADDR_VAL0   = 6'b110000;
  localparam logic [5:0] ADDR_VAL1   = 6'b110001;
  localparam logic [5:0] ADDR_VAL2   = 6'b110010;
  localparam logic [5:0] ADDR_STATUS = 6'b110011;

  logic [2:0][31:0] port_in;
  logic [2:0][31:0] val_bus;
  logic [2:0]       chg_bus;
  logic             status_clear;
  logic             unused_ok;

  assign port_in[0] = in_port0;
  assign port_in[1] = in_port1;
  assign port_in[2] = in_port2;

  assign status_clear = read_io_enable && (addr[7:2] == ADDR_STATUS);

  // Only addr[7:2] participates in the decode.
  assign unused_ok = ^{addr[31:8], addr[1:0], 8'(DEBOUNCE_CYCLES)};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_port
      logic [31:0] sync1_reg;
      logic [31:0] sync2_reg;
      logic [31:0] val_reg;
      logic [31:0] val_next;
      logic        chg_reg;
      logic        chg_next;
      logic        load;

`ifdef IO_DEBOUNCE_EN
      logic [7:0] cnt_reg;
      logic [7:0] cnt_next;

      // Load only on the DEBOUNCE_CYCLES-th consecutive edge where sync2 differs from val.
      always_comb begin
        val_next = val_reg;
        load     = 1'b0;
        cnt_next = 8'd0;
        if (sync2_reg != val_reg) begin
          if (cnt_reg == 8'(DEBOUNCE_CYCLES - 1)) begin
            load     = 1'b1;
            val_next = sync2_reg;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end

      always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
          cnt_reg <= 8'd0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end
`else
      always_comb begin
        val_next = sync2_reg;
        load     = (sync2_reg != val_reg);
      end
`endif

      // A new change on this port outranks a status clear on the same edge.
      assign chg_next = load | (chg_reg & ~status_clear);

      always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
          sync1_reg <= 32'h0;
          sync2_reg <= 32'h0;
          val_reg   <= 32'h0;
          chg_reg   <= 1'b0;
        end else begin
          sync1_reg <= port_in[gi];
          sync2_reg <= sync1_reg;
          val_reg   <= val_next;
          chg_reg   <= chg_next;
        end
      end

      assign val_bus[gi] = val_reg;
      assign chg_bus[gi] = chg_reg;
    end
  endgenerate

  always_comb begin
    dataout = 32'h0;
    case (addr[7:2])
      ADDR_VAL0:   dataout = val_bus[0];
      ADDR_VAL1:   dataout = val_bus[1];
      ADDR_VAL2:   dataout = val_bus[2];
      ADDR_STATUS: dataout = {29'b0, chg_bus};
      default:     dataout = 32'h0;
    endcase
  end

  assign io_irq = |chg_bus;

endmodule

// File: tb/tb_io_input_reg.sv
// Directed testbench for io_input_reg: reset, read decode, flag clear, collision, debounce/glitch.
module tb_io_input_reg;

`ifdef IO_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic        io_clk = 1'b0;
  logic        clrn = 1'b0;
  logic [31:0] addr = 32'h0;
  logic        read_io_enable = 1'b0;
  logic [31:0] in_port0 = 32'h0;
  logic [31:0] in_port1 = 32'h0;
  logic [31:0] in_port2 = 32'h0;
  logic [31:0] dataout;
  logic        io_irq;

  int vectors = 0;
  int miscompares = 0;

  io_input_reg #(.DEBOUNCE_CYCLES(4)) dut (
    .io_clk(io_clk),
    .clrn(clrn),
    .addr(addr),
    .read_io_enable(read_io_enable),
    .in_port0(in_port0),
    .in_port1(in_port1),
    .in_port2(in_port2),
    .dataout(dataout),
    .io_irq(io_irq)
  );

  always #5 io_clk = ~io_clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge io_clk);
      #1;
    end
  endtask

  task automatic peek(input logic [31:0] a);
    addr = a;
    #1;
    $display("read addr=%h dataout=%h io_irq=%b", addr, dataout, io_irq);
  endtask

  task automatic status_clear_cycle();
    addr = 32'h0000_00CC;
    read_io_enable = 1'b1;
    tick(1);
    read_io_enable = 1'b0;
  endtask

  task automatic test_reset();
    in_port0 = 32'hFFFF_FFFF;
    tick(2);
    peek(32'h0000_00C0);
    vectors++; if (dataout !== 32'h0) begin miscompares++; $display("FAIL reset_val0 got=%h exp=%h", dataout, 32'h0); end
    vectors++; if (io_irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got=%b exp=0", io_irq); end
    peek(32'h0000_00CC);
    vectors++; if (dataout !== 32'h0) begin miscompares++; $display("FAIL reset_status got=%h exp=%h", dataout, 32'h0); end
    #1 clrn = 1'b1;
    tick(LAT - 1);
    peek(32'h0000_00C0);
    vectors++; if (dataout !== 32'h0) begin miscompares++; $display("FAIL reset_early_val0 got=%h exp=%h", dataout, 32'h0); end
    tick(1);
    peek(32'h0000_00C0);
    vectors++; if (dataout !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL reset_lat_val0 got=%h exp=%h", dataout, 32'hFFFF_FFFF); end
    peek(32'h0000_00CC);
    vectors++; if (dataout !== 32'h1) begin miscompares++; $display("FAIL reset_chg0 got=%h exp=%h", dataout, 32'h1); end
    vectors++; if (io_irq !== 1'b1) begin miscompares++; $display("FAIL reset_chg0_irq got=%b exp=1", io_irq); end
  endtask

  task automatic test_clear();
    status_clear_cycle();
    peek(32'h0000_00CC);
    vectors++; if (dataout !== 32'h0) begin miscompares++; $display("FAIL clear_status got=%h exp=%h", dataout, 32'h0); end
    vectors++; if (io_irq !== 1'b0) begin miscompares++; $display("FAIL clear_irq got=%b exp=0", io_irq); end
  endtask

  task automatic test_read_path();
    in_port1 = 32'h1234_5678;
    tick(LAT);
    peek(32'h0000_00C4);
    vectors++; if (dataout !== 32'h1234_5678) begin miscompares++; $display("FAIL read_val1 got=%h exp=%h", dataout, 32'h1234_5678); end
    peek(32'h0000_00CC);
    vectors++; if (dataout !== 32'h2) begin miscompares++; $display("FAIL read_status got=%h exp=%h", dataout, 32'h2); end
    vectors++; if (io_irq !== 1'b1) begin miscompares++; $display("FAIL read_irq got=%b exp=1", io_irq); end
  endtask

  task automatic test_decode();
    addr = 32'h0000_0080;
    read_io_enable = 1'b1;
    tick(1);
    read_io_enable = 1'b0;
    peek(32'h0000_0080);
    vectors++; if (dataout !== 32'h0) begin miscompares++; $display("FAIL decode_outspace got=%h exp=%h", dataout, 32'h0); end
    addr = 32'h0000_00C4;
    read_io_enable = 1'b1;
    tick(1);
    read_io_enable = 1'b0;
    peek(32'hFFFF_FFC4);
    vectors++; if (dataout !== 32'h1234_5678) begin miscompares++; $display("FAIL decode_highbits got=%h exp=%h", dataout, 32'h1234_5678); end
    peek(32'h0000_00C8);
    vectors++; if (dataout !== 32'h0) begin miscompares++; $display("FAIL decode_val2 got=%h exp=%h", dataout, 32'h0); end
    peek(32'h0000_00CC);
    vectors++; if (dataout !== 32'h2) begin miscompares++; $display("FAIL decode_flags_kept got=%h exp=%h", dataout, 32'h2); end
    status_clear_cycle();
  endtask

  task automatic test_collision();
    in_port1 = 32'h0;
    tick(LAT);
    peek(32'h0000_00CC);
    vectors++; if (dataout !== 32'h2) begin miscompares++; $display("FAIL coll_pre got=%h exp=%h", dataout, 32'h2); end
    in_port2 = 32'hA5A5_0001;
    tick(LAT - 1);
    status_clear_cycle();
    peek(32'h0000_00CC);
    vectors++; if (dataout !== 32'h4) begin miscompares++; $display("FAIL coll_status got=%h exp=%h", dataout, 32'h4); end
    peek(32'h0000_00C8);
    vectors++; if (dataout !== 32'hA5A5_0001) begin miscompares++; $display("FAIL coll_val2 got=%h exp=%h", dataout, 32'hA5A5_0001); end
    status_clear_cycle();
  endtask

  task automatic test_multi();
    in_port0 = 32'h7FFF_FFFF;
    in_port1 = 32'h0000_0001;
    in_port2 = 32'hA5A5_0000;
    tick(LAT - 1);
    peek(32'h0000_00CC);
    vectors++; if (dataout !== 32'h0) begin miscompares++; $display("FAIL multi_early got=%h exp=%h", dataout, 32'h0); end
    tick(1);
    peek(32'h0000_00CC);
    vectors++; if (dataout !== 32'h7) begin miscompares++; $display("FAIL multi_status got=%h exp=%h", dataout, 32'h7); end
    peek(32'h0000_00C0);
    vectors++; if (dataout !== 32'h7FFF_FFFF) begin miscompares++; $display("FAIL multi_val0 got=%h exp=%h", dataout, 32'h7FFF_FFFF); end
    status_clear_cycle();
  endtask

  task automatic test_glitch();
    in_port0 = 32'h0;
    tick(LAT + 1);
    status_clear_cycle();
`ifdef IO_DEBOUNCE_EN
    in_port0 = 32'h5;
    tick(3);
    in_port0 = 32'h0;
    tick(8);
    peek(32'h0000_00C0);
    vectors++; if (dataout !== 32'h0) begin miscompares++; $display("FAIL glitch_val0 got=%h exp=%h", dataout, 32'h0); end
    peek(32'h0000_00CC);
    vectors++; if (dataout !== 32'h0) begin miscompares++; $display("FAIL glitch_status got=%h exp=%h", dataout, 32'h0); end
    in_port0 = 32'h5;
    tick(5);
    peek(32'h0000_00C0);
    vectors++; if (dataout !== 32'h0) begin miscompares++; $display("FAIL hold_early got=%h exp=%h", dataout, 32'h0); end
    tick(1);
    peek(32'h0000_00C0);
    vectors++; if (dataout !== 32'h5) begin miscompares++; $display("FAIL hold_val0 got=%h exp=%h", dataout, 32'h5); end
`else
    in_port0 = 32'h5;
    tick(1);
    in_port0 = 32'h0;
    tick(2);
    peek(32'h0000_00C0);
    vectors++; if (dataout !== 32'h5) begin miscompares++; $display("FAIL pulse_val0 got=%h exp=%h", dataout, 32'h5); end
    tick(1);
    peek(32'h0000_00C0);
    vectors++; if (dataout !== 32'h0) begin miscompares++; $display("FAIL pulse_back got=%h exp=%h", dataout, 32'h0); end
`endif
    peek(32'h0000_00CC);
    vectors++; if (dataout !== 32'h1) begin miscompares++; $display("FAIL glitch_chg0 got=%h exp=%h", dataout, 32'h1); end
  endtask

  task automatic test_async_reset();
    in_port2 = 32'h0000_0F00;
    tick(LAT);
    peek(32'h0000_00C8);
    vectors++; if (io_irq !== 1'b1) begin miscompares++; $display("FAIL areset_pre_irq got=%b exp=1", io_irq); end
    #2 clrn = 1'b0;
    peek(32'h0000_00C8);
    vectors++; if (dataout !== 32'h0) begin miscompares++; $display("FAIL areset_val2 got=%h exp=%h", dataout, 32'h0); end
    vectors++; if (io_irq !== 1'b0) begin miscompares++; $display("FAIL areset_irq got=%b exp=0", io_irq); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_read_path();
    test_decode();
    test_collision();
    test_multi();
    test_glitch();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/io_input_reg.md
IO_INPUT_REG -- requirements
Module: io_input_reg

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the consecutive stable io_clk edges required before a debounced port value updates (legal range 1..255).
REQ-002 SHALL have port io_clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port clrn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port addr  input  32  CPU byte address; only addr[7:2] is decoded.
REQ-005 SHALL have port read_io_enable  input  1  CPU IO read strobe, sampled at rising io_clk.
REQ-006 SHALL have ports in_port0, in_port1, in_port2  input  32 each  external, asynchronous input ports.
REQ-007 SHALL have port dataout  output  32  read data to the CPU.
REQ-008 SHALL have port io_irq  output  1  high while any change flag is set.

Function
REQ-009 SHALL pass each in_portN through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-010 SHALL hold one 32-bit visible register valN per port; without debounce, valN <= sync2N on every edge.
REQ-011 SHALL set change flag chgN on the edge where valN is loaded with a value different from its previous value.
REQ-012 SHALL decode addr[7:2] combinationally: 6'b110000 -> val0, 6'b110001 -> val1, 6'b110010 -> val2, 6'b110011 -> status {29'b0, chg2, chg1, chg0}; any other code -> 32'h0.
REQ-013 SHALL drive dataout from the REQ-012 decode, independent of read_io_enable.
REQ-014 SHALL clear chg2..chg0 on the rising edge where read_io_enable=1 and addr[7:2]=6'b110011.
REQ-015 SHALL keep chgN set if a status clear and a new change on port N occur on the same edge; new event wins.
REQ-016 SHALL leave flags unchanged on reads of port addresses and on non-decoded addresses.
REQ-017 SHALL drive io_irq = chg0 | chg1 | chg2, combinationally from the flag registers.
REQ-018 SHALL have an input-to-valN latency of exactly 3 edges without debounce: sync1 at edge 1, sync2 at edge 2, val at edge 3.
REQ-019 SHALL count a 32-bit value as one unit; any bit difference is a change.
REQ-020 SHALL treat ports independently; simultaneous changes on several ports set each corresponding flag on the same edge.

Reset
REQ-021 SHALL, while clrn=0, asynchronously clear all sync flops, val0..val2, chg0..chg2 and debounce counters to 0.
REQ-022 SHALL give dataout=0 and io_irq=0 during reset.
REQ-023 SHALL, on deassertion, treat the first nonzero input as a change: it sets the flag after the normal latency.
REQ-024 SHALL abort any debounce count in progress when reset asserts mid-operation.

Configuration
REQ-025 SHALL, when macro IO_DEBOUNCE_EN is defined, give each port an 8-bit counter cntN.
REQ-026 SHALL increment cntN on each edge where sync2N != valN.
REQ-027 SHALL clear cntN on any edge where sync2N == valN.
REQ-028 SHALL, on the DEBOUNCE_CYCLES-th consecutive mismatch edge, load valN <= sync2N, set chgN and clear cntN.
REQ-029 SHALL, with IO_DEBOUNCE_EN defined, have an input-to-val latency of 2+DEBOUNCE_CYCLES edges for a stable input.
REQ-030 SHALL, with IO_DEBOUNCE_EN defined, never update valN for glitches shorter than DEBOUNCE_CYCLES edges.
REQ-031 SHALL, when IO_DEBOUNCE_EN is undefined, contain no counters and behave per REQ-010/REQ-018.

Verification
REQ-032 Reset: clrn=0 with in_port0=32'hFFFF_FFFF -> dataout=0, io_irq=0; release clrn -> 3 edges later val0=32'hFFFF_FFFF, chg0=1.
REQ-033 Read path: in_port1=32'h1234_5678 stable, addr=32'h0000_00C4 -> dataout=32'h1234_5678; addr=32'h0000_00CC -> dataout=32'h0000_0002, io_irq=1.
REQ-034 Clear: status read with read_io_enable=1 at addr 0xCC -> next cycle status=0, io_irq=0.
REQ-035 Collision: in_port2 change timed so val2 updates on the same edge as a status clear -> status=32'h4 afterwards.
REQ-036 Decode: addr=32'h0000_0080 (output-port space) -> dataout=0, flags unchanged.
REQ-037 Debounce (IO_DEBOUNCE_EN, DEBOUNCE_CYCLES=4): 3-cycle pulse 0->5->0 on in_port0 -> val0 stays 0, chg0=0; 6-cycle hold of 5 -> val0=5 exactly 6 edges after the input change, chg0=1.
